fetch_unit: RTL and testbench

//  IF stage of the 5-stage RV32I pipeline: owns the PC register, computes next PC from the hazard

---
 rtl/fetch_unit.sv | 134 +++++++++++++
 tb/tb_fetch_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// IF stage of the RV32I pipeline: PC register, next-PC selection, single-outstanding
// req/gnt/rvalid instruction fetch with redirect squashing, and the IF/ID register.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        stall_IF,
  input  logic        flush_IF,
  input  logic [2:0]  NPCOp,
  input  logic [31:0] NPCImm,
  input  logic [31:0] base_PC,
  input  logic [31:0] alu_result_EX,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_IF,
  output logic [31:0] PC_ID,
  output logic [31:0] instr_ID,
  output logic        valid_ID
);

  localparam logic [2:0] NPC_PLUS4  = 3'b000;
  localparam logic [2:0] NPC_BRANCH = 3'b001;
  localparam logic [2:0] NPC_JUMP   = 3'b010;
  localparam logic [2:0] NPC_JALR   = 3'b100;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] pc_id_q, pc_id_d;
  logic [31:0] instr_id_q, instr_id_d;
  logic        valid_id_q, valid_id_d;

  logic        req;
  logic        fire;
  logic        rdata_hit;
  logic        avail;
  logic [31:0] avail_instr;
  logic        redirect;
  logic [31:0] target;

  always_comb begin
    unique case (NPCOp)
      NPC_BRANCH, NPC_JUMP: target = base_PC + NPCImm;
      NPC_JALR:             target = alu_result_EX & ~32'h1;
      default:              target = pc_q + 32'd4;
    endcase
  end

  always_comb begin
    req         = (state_q == S_REQ) && !buf_valid_q;
    fire        = req && imem_gnt;
    rdata_hit   = (state_q == S_WAIT) && imem_rvalid;
    avail       = rdata_hit || buf_valid_q;
    avail_instr = rdata_hit ? imem_rdata : buf_q;
    redirect    = (NPCOp != NPC_PLUS4) && !stall_IF;

    state_d     = state_q;
    pc_d        = pc_q;
    buf_d       = buf_q;
    buf_valid_d = buf_valid_q;
    pc_id_d     = pc_id_q;
    instr_id_d  = instr_id_q;
    valid_id_d  = valid_id_q;

    unique case (state_q)
      S_REQ:   if (fire) state_d = S_WAIT;
      S_WAIT:  if (imem_rvalid) state_d = S_REQ;
      S_DROP:  if (imem_rvalid) state_d = S_REQ;
      default: state_d = S_REQ;
    endcase

    if (stall_IF) begin
      if (rdata_hit) begin
        buf_d       = imem_rdata;
        buf_valid_d = 1'b1;
      end
    end else if (redirect || flush_IF) begin
      pc_d        = redirect ? target : pc_q + 32'd4;
      buf_valid_d = 1'b0;
      pc_id_d     = '0;
      instr_id_d  = NOP_INSTR;
      valid_id_d  = 1'b0;
      // A request granted now or still awaiting its response belongs to the old path.
      if (fire || ((state_q == S_WAIT) && !imem_rvalid))
        state_d = S_DROP;
    end else if (avail) begin
      pc_id_d     = pc_q;
      instr_id_d  = avail_instr;
      valid_id_d  = 1'b1;
      pc_d        = pc_q + 32'd4;
      buf_valid_d = 1'b0;
    end else begin
      pc_id_d    = '0;
      instr_id_d = NOP_INSTR;
      valid_id_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      buf_q       <= '0;
      buf_valid_q <= 1'b0;
      pc_id_q     <= '0;
      instr_id_q  <= NOP_INSTR;
      valid_id_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      buf_q       <= buf_d;
      buf_valid_q <= buf_valid_d;
      pc_id_q     <= pc_id_d;
      instr_id_q  <= instr_id_d;
      valid_id_q  <= valid_id_d;
    end
  end

  assign imem_req  = req;
  assign imem_addr = pc_q;
  assign PC_IF     = pc_q;
  assign PC_ID     = pc_id_q;
  assign instr_ID  = instr_id_q;
  assign valid_ID  = valid_id_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a per-cycle vector table run against a zero-wait memory,
// followed by hand-driven sequences for redirect-drop, stall buffering and mid-fetch reset.
module tb_fetch_unit;

  localparam logic [2:0] OP_P = 3'b000;
  localparam logic [2:0] OP_B = 3'b001;
  localparam logic [2:0] OP_J = 3'b010;
  localparam logic [2:0] OP_R = 3'b100;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rstn;
  logic        stall_IF, flush_IF;
  logic [2:0]  NPCOp;
  logic [31:0] NPCImm, base_PC, alu_result_EX;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] PC_IF, PC_ID, instr_ID;
  logic        valid_ID;

  logic        auto_mem;
  logic        gnt_man;
  int unsigned nvec = 0;
  int unsigned nerr = 0;

  always #5 clk = ~clk;

  assign imem_gnt = auto_mem ? imem_req : gnt_man;

  fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0013)) dut (
    .clk(clk), .rstn(rstn), .stall_IF(stall_IF), .flush_IF(flush_IF),
    .NPCOp(NPCOp), .NPCImm(NPCImm), .base_PC(base_PC), .alu_result_EX(alu_result_EX),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .PC_IF(PC_IF), .PC_ID(PC_ID), .instr_ID(instr_ID), .valid_ID(valid_ID)
  );

  typedef struct {
    logic        stall;
    logic        flush;
    logic [2:0]  op;
    logic [31:0] alu;
    logic [31:0] e_pc;
    logic        e_req;
    logic        e_v;
    logic [31:0] e_pcid;
    logic [31:0] e_instr;
  } vec_t;

  vec_t tbl [14];

  function automatic vec_t mk(input logic st, input logic fl, input logic [2:0] op,
                              input logic [31:0] alu, input logic [31:0] pc, input logic rq,
                              input logic v, input logic [31:0] pcid, input logic [31:0] ins);
    vec_t r;
    r.stall = st; r.flush = fl; r.op = op; r.alu = alu;
    r.e_pc = pc; r.e_req = rq; r.e_v = v; r.e_pcid = pcid; r.e_instr = ins;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Advance one clock; in auto mode the memory answers every grant on the next cycle with addr>>2.
  task automatic step();
    logic        fire;
    logic [31:0] a;
    #1;
    fire = imem_req && imem_gnt;
    a    = imem_addr;
    @(posedge clk);
    #1;
    if (auto_mem) begin
      imem_rvalid = fire;
      imem_rdata  = a >> 2;
    end
  endtask

  task automatic drive(input logic st, input logic fl, input logic [2:0] op,
                       input logic [31:0] imm, input logic [31:0] base, input logic [31:0] alu);
    stall_IF = st; flush_IF = fl; NPCOp = op; NPCImm = imm; base_PC = base; alu_result_EX = alu;
  endtask

  task automatic chk_ifid(input string nm, input logic [31:0] pc, input logic [31:0] ins, input logic v);
    chk({nm, ".valid_ID"}, {31'd0, valid_ID}, {31'd0, v});
    chk({nm, ".instr_ID"}, instr_ID, ins);
    if (v) chk({nm, ".PC_ID"}, PC_ID, pc);
  endtask

  initial begin
    tbl[0]  = mk(0, 0, OP_P, 32'h0,   32'h000, 0, 0, 32'h000, NOP);
    tbl[1]  = mk(0, 0, OP_P, 32'h0,   32'h004, 1, 1, 32'h000, 32'h0);
    tbl[2]  = mk(0, 0, OP_P, 32'h0,   32'h004, 0, 0, 32'h000, NOP);
    tbl[3]  = mk(0, 0, OP_P, 32'h0,   32'h008, 1, 1, 32'h004, 32'h1);
    tbl[4]  = mk(0, 0, OP_P, 32'h0,   32'h008, 0, 0, 32'h000, NOP);
    tbl[5]  = mk(0, 0, OP_P, 32'h0,   32'h00C, 1, 1, 32'h008, 32'h2);
    tbl[6]  = mk(0, 0, OP_P, 32'h0,   32'h00C, 0, 0, 32'h000, NOP);
    tbl[7]  = mk(0, 0, OP_R, 32'h105, 32'h104, 1, 0, 32'h000, NOP);
    tbl[8]  = mk(0, 0, OP_P, 32'h0,   32'h104, 0, 0, 32'h000, NOP);
    tbl[9]  = mk(0, 0, OP_P, 32'h0,   32'h108, 1, 1, 32'h104, 32'h41);
    tbl[10] = mk(0, 0, OP_P, 32'h0,   32'h108, 0, 0, 32'h000, NOP);
    tbl[11] = mk(0, 1, OP_P, 32'h0,   32'h10C, 1, 0, 32'h000, NOP);
    tbl[12] = mk(0, 0, OP_P, 32'h0,   32'h10C, 0, 0, 32'h000, NOP);
    tbl[13] = mk(0, 0, OP_P, 32'h0,   32'h110, 1, 1, 32'h10C, 32'h43);

    rstn = 1'b0; auto_mem = 1'b1; gnt_man = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0;
    drive(0, 0, OP_P, 32'h0, 32'h0, 32'h0);

    #12;
    chk("rst.PC_IF", PC_IF, 32'h0);
    chk("rst.PC_ID", PC_ID, 32'h0);
    chk_ifid("rst", 32'h0, NOP, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("rel.imem_req", {31'd0, imem_req}, 32'd1);
    chk("rel.imem_addr", imem_addr, 32'h0);

    // T1 zero-wait streaming, T3 JALR masking, flush as redirect to PC+4
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].stall, tbl[i].flush, tbl[i].op, 32'h0, 32'h0, tbl[i].alu);
      step();
      chk($sformatf("vec%0d.PC_IF", i), PC_IF, tbl[i].e_pc);
      chk($sformatf("vec%0d.imem_req", i), {31'd0, imem_req}, {31'd0, tbl[i].e_req});
      chk_ifid($sformatf("vec%0d", i), tbl[i].e_pcid, tbl[i].e_instr, tbl[i].e_v);
    end

    // T2 branch during S_WAIT with late rvalid: stale word dropped
    auto_mem = 1'b0; imem_rvalid = 1'b0; gnt_man = 1'b1;
    drive(0, 0, OP_P, 32'h0, 32'h0, 32'h0);
    step();
    chk("t2.wait_req", {31'd0, imem_req}, 32'd0);
    gnt_man = 1'b0;
    drive(0, 0, OP_B, 32'hFFFF_FFF8, 32'h10, 32'h0);
    step();
    chk("t2.redir_pc", PC_IF, 32'h08);
    chk_ifid("t2.redir", 32'h0, NOP, 1'b0);
    chk("t2.drop_req", {31'd0, imem_req}, 32'd0);
    drive(0, 0, OP_P, 32'h0, 32'h0, 32'h0);
    step();
    chk("t2.drop_hold_req", {31'd0, imem_req}, 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    step();
    chk_ifid("t2.stale", 32'h0, NOP, 1'b0);
    chk("t2.req", {31'd0, imem_req}, 32'd1);
    chk("t2.addr", imem_addr, 32'h08);
    imem_rvalid = 1'b0; gnt_man = 1'b1;
    step();
    gnt_man = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
    step();
    imem_rvalid = 1'b0;
    chk_ifid("t2.fetch", 32'h08, 32'h1234_5678, 1'b1);
    chk("t2.pc", PC_IF, 32'h0C);

    // T4 stall for 3 cycles while the response arrives
    drive(0, 0, OP_J, 32'h0, 32'h20, 32'h0);
    step();
    chk("t4.redir_pc", PC_IF, 32'h20);
    drive(0, 0, OP_P, 32'h0, 32'h0, 32'h0);
    gnt_man = 1'b1;
    step();
    gnt_man = 1'b0;
    drive(1, 0, OP_P, 32'h0, 32'h0, 32'h0);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_rvalid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      chk($sformatf("t4.stall%0d.req", c), {31'd0, imem_req}, 32'd0);
      chk($sformatf("t4.stall%0d.pc", c), PC_IF, 32'h20);
      chk_ifid($sformatf("t4.stall%0d", c), 32'h0, NOP, 1'b0);
      step();
    end
    chk("t4.stall2.req", {31'd0, imem_req}, 32'd0);
    stall_IF = 1'b0;
    step();
    chk_ifid("t4.release", 32'h20, 32'hDEAD_BEEF, 1'b1);
    chk("t4.next_req", {31'd0, imem_req}, 32'd1);
    chk("t4.next_addr", imem_addr, 32'h24);

    // T5 jump ignored while stalled, taken once stall drops
    drive(1, 0, OP_J, 32'h10, 32'h40, 32'h0);
    for (int c = 0; c < 2; c++) begin
      step();
      chk($sformatf("t5.stall%0d.pc", c), PC_IF, 32'h24);
      chk_ifid($sformatf("t5.stall%0d", c), 32'h20, 32'hDEAD_BEEF, 1'b1);
    end
    stall_IF = 1'b0;
    step();
    chk("t5.jump_pc", PC_IF, 32'h50);
    chk_ifid("t5.jump", 32'h0, NOP, 1'b0);

    // T6 reset pulse in S_WAIT; stale rvalid after release is ignored
    drive(0, 0, OP_P, 32'h0, 32'h0, 32'h0);
    gnt_man = 1'b1;
    step();
    gnt_man = 1'b0;
    chk("t6.wait_req", {31'd0, imem_req}, 32'd0);
    #2 rstn = 1'b0;
    #1;
    chk("t6.async_pc", PC_IF, 32'h0);
    chk("t6.async_req", {31'd0, imem_req}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_0BAD;
    step();
    imem_rvalid = 1'b0;
    chk_ifid("t6.stale", 32'h0, NOP, 1'b0);
    chk("t6.pc", PC_IF, 32'h0);
    chk("t6.req", {31'd0, imem_req}, 32'd1);
    gnt_man = 1'b1;
    step();
    gnt_man = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0077;
    step();
    imem_rvalid = 1'b0;
    chk_ifid("t6.fetch", 32'h0, 32'h77, 1'b1);
    chk("t6.pc4", PC_IF, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
